msrv32_pc_gen: RTL and testbench
================================

# msrv32_pc_gen

Program-counter generator and instruction-fetch sequencer for the msrv32 core. It takes the resolved redirect from the branch unit (`branch_taken_in` plus target address) and issues fetch requests to instruction memory over a request/grant/rvalid handshake. It keeps one request outstanding, discards responses made stale by a redirect, and hands fetched instructions to decode through a one-entry valid/ready buffer.

## Interface
- `BOOT_ADDR`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: value driven on `instr_out` when there is no valid instruction.

- `clk_in`  in  1: single clock, rising edge.
- `rst_n_in`  in  1: synchronous, active-low reset.
- `branch_taken_in`  in  1: redirect strobe from the branch unit (branch taken, JAL, JALR).
- `iaddr_in`  in  32: redirect target; sampled only when `branch_taken_in`=1.
- `imem_req_out`  out  1: fetch request.
- `imem_addr_out`  out  32: fetch address; held stable while `imem_req_out`=1.
- `imem_gnt_in`  in  1: request accepted this cycle.
- `imem_rvalid_in`  in  1: read data valid.
- `imem_rdata_in`  in  32: instruction word.
- `instr_valid_out`  out  1: buffered instruction valid.
- `instr_ready_in`  in  1: decode accepts the instruction.
- `instr_out`  out  32: instruction word.
- `pc_out`  out  32: address of `instr_out`.
- `misaligned_out`  out  1: misaligned-target pulse. Present only with `MSRV32_MISALIGN_TRAP_EN`.

## Operation
- Internal registers: `fetch_pc` (next address), `kill` (outstanding response is stale), output buffer {valid, instr, pc}, and state.
- States:
  - BOOT: entered on reset. Moves to REQ on the first cycle `rst_n_in`=1.
  - REQ: `imem_req_out`=1 with `imem_addr_out`=`fetch_pc`. Requests are issued only when the buffer is empty or is being consumed this cycle. On `imem_gnt_in`: `fetch_pc` <= `fetch_pc`+4 (mod 2^32; wraps from 32'hFFFF_FFFC to 0), then go to WAIT.
  - WAIT: waits for `imem_rvalid_in`.
    - If `kill`=0, load the buffer with {1, `imem_rdata_in`, address of the granted request}.
    - If `kill`=1, drop the data and clear `kill`.
    - Return to REQ.
  - HOLD: exists only with the macro. `imem_req_out`=0 until the next `branch_taken_in`.
- Redirect: when `branch_taken_in`=1, in any state except BOOT:
  - `fetch_pc` <= {`iaddr_in`[31:1], 1'b0}.
  - The buffer is invalidated in the same cycle.
  - If a request has been granted but its response has not arrived, set `kill`.
  - If the redirect occurs in REQ before grant, the address changes next cycle. This is the only permitted address change while requesting.
  - Priority: a redirect overrides a `+4` update that is granted in the same cycle; that grant's response is killed.
- `imem_rvalid_in` with `kill`=1 in the same cycle as a new redirect: drop the data, and `kill` stays cleared, because no request is outstanding.
- The buffer holds while `instr_valid_out`=1 and `instr_ready_in`=0.

## Timing
- Reset values:
  - `imem_req_out`=0, `imem_addr_out`=`BOOT_ADDR`
  - `instr_valid_out`=0, `instr_out`=`NOP_INSTR`, `pc_out`=`BOOT_ADDR`
  - `misaligned_out`=0, `kill`=0, state BOOT
- Reset mid-transaction aborts everything. Responses arriving after reset are ignored until a new grant.
- First request: the cycle after `rst_n_in` is sampled high.
- Grant to rvalid: at least 1 cycle. Rvalid to `instr_valid_out`: 1 cycle.
- Redirect with no outstanding request: `imem_addr_out`=target in cycle N+1.
- Redirect with an outstanding request: target is requested in the cycle after the stale rvalid.
- Back-to-back throughput, with grant in the same cycle and rvalid the next: one instruction every 2 cycles.

## Configuration
- `MSRV32_MISALIGN_TRAP_EN` defined: a redirect with `iaddr_in`[1]=1 pulses `misaligned_out` for one cycle (N+1). It still loads `fetch_pc` and kills in-flight data, then enters HOLD, issuing no fetch until the next `branch_taken_in`.
- `MSRV32_MISALIGN_TRAP_EN` undefined: the port is absent, bit 1 is forwarded unchanged, and there is no HOLD state.

## Test plan
- Reset, then release with zero-wait memory: addresses 0, 4, 8 are requested. `instr_valid_out` first rises 3 cycles after release, with `pc_out`=0.
- `branch_taken_in`=1 with `iaddr_in`=32'h0000_0105 while WAIT for 8: the rvalid data for 8 is dropped, the next request is 32'h0000_0104, and no instruction from 8 appears.
- `instr_ready_in`=0 for 5 cycles with the buffer full: `imem_req_out` stays 0 and `instr_out`/`pc_out` hold stable.
- `fetch_pc`=32'hFFFF_FFFC granted: the next request address is 32'h0000_0000.
- With the macro, `iaddr_in`=32'h0000_0202: `misaligned_out`=1 for exactly one cycle and `imem_req_out` stays 0. A following redirect to 32'h0000_0300 resumes fetch.
- `rst_n_in`=0 during WAIT, then an rvalid arrives: `instr_valid_out` stays 0 and the first post-reset request is `BOOT_ADDR`.

Source files
------------

// File: rtl/msrv32_pc_gen_if.sv
// Fetch-side bundle for msrv32_pc_gen: redirect input, imem handshake and decode buffer.
// The misaligned_out pulse exists only when MSRV32_MISALIGN_TRAP_EN is defined.
interface msrv32_pc_gen_if;
  logic        branch_taken_in;
  logic [31:0] iaddr_in;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_gnt_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
`ifdef MSRV32_MISALIGN_TRAP_EN
  logic        misaligned_out;
`endif

  modport master (
    input  branch_taken_in, iaddr_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
`ifdef MSRV32_MISALIGN_TRAP_EN
    output misaligned_out,
`endif
    output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out
  );

  modport slave (
    output branch_taken_in, iaddr_in, imem_gnt_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
`ifdef MSRV32_MISALIGN_TRAP_EN
    input  misaligned_out,
`endif
    input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out
  );
endinterface

// File: rtl/msrv32_pc_gen.sv
// PC generator / fetch sequencer: one outstanding imem request, stale-response kill, one-entry decode buffer.
// Optional MSRV32_MISALIGN_TRAP_EN adds the misaligned-target pulse and the HOLD state.
module msrv32_pc_gen #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic            clk_in,
  input logic            rst_n_in,
  msrv32_pc_gen_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT
`ifdef MSRV32_MISALIGN_TRAP_EN
    , ST_HOLD
`endif
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] req_pc_reg;
  logic        kill_reg;
  logic        buf_valid_reg;
  logic [31:0] buf_instr_reg;
  logic [31:0] buf_pc_reg;
`ifdef MSRV32_MISALIGN_TRAP_EN
  logic        misaligned_reg;
`endif

  logic        redirect;
  logic [31:0] target;
  logic        buf_free;
  logic        req;
  logic        granted;
  logic        in_flight_next;
  logic        iaddr_unused;

  assign redirect = bus.branch_taken_in && (state_reg != ST_BOOT);
  assign target   = {bus.iaddr_in[31:1], 1'b0};
  assign iaddr_unused = bus.iaddr_in[0];

  // A request may only go out if its response will find the buffer free.
  assign buf_free = !buf_valid_reg || bus.instr_ready_in;
  assign req      = (state_reg == ST_REQ) && buf_free;
  assign granted  = req && bus.imem_gnt_in;

  // kill_reg is only ever set while a response is still owed (WAIT or HOLD).
  assign in_flight_next = granted ||
                          (((state_reg == ST_WAIT) || kill_reg) && !bus.imem_rvalid_in);

  assign bus.imem_req_out    = req;
  assign bus.imem_addr_out   = fetch_pc_reg;
  assign bus.instr_valid_out = buf_valid_reg;
  assign bus.instr_out       = buf_valid_reg ? buf_instr_reg : NOP_INSTR;
  assign bus.pc_out          = buf_pc_reg;
`ifdef MSRV32_MISALIGN_TRAP_EN
  assign bus.misaligned_out  = misaligned_reg;
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_reg      <= ST_BOOT;
      fetch_pc_reg   <= BOOT_ADDR;
      req_pc_reg     <= BOOT_ADDR;
      kill_reg       <= 1'b0;
      buf_valid_reg  <= 1'b0;
      buf_instr_reg  <= NOP_INSTR;
      buf_pc_reg     <= BOOT_ADDR;
`ifdef MSRV32_MISALIGN_TRAP_EN
      misaligned_reg <= 1'b0;
`endif
    end else begin
`ifdef MSRV32_MISALIGN_TRAP_EN
      misaligned_reg <= 1'b0;
`endif
      if (buf_valid_reg && bus.instr_ready_in) begin
        buf_valid_reg <= 1'b0;
      end

      case (state_reg)
        ST_BOOT: state_reg <= ST_REQ;
        ST_REQ: begin
          if (granted) begin
            req_pc_reg   <= fetch_pc_reg;
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
            state_reg    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid_in) begin
            if (!kill_reg) begin
              buf_valid_reg <= 1'b1;
              buf_instr_reg <= bus.imem_rdata_in;
              buf_pc_reg    <= req_pc_reg;
            end
            kill_reg  <= 1'b0;
            state_reg <= ST_REQ;
          end
        end
`ifdef MSRV32_MISALIGN_TRAP_EN
        ST_HOLD: begin
          if (bus.imem_rvalid_in) begin
            kill_reg <= 1'b0;
          end
        end
`endif
        default: state_reg <= ST_BOOT;
      endcase

      // Redirect wins over everything above, including a same-cycle grant or load.
      if (redirect) begin
        fetch_pc_reg  <= target;
        buf_valid_reg <= 1'b0;
        kill_reg      <= in_flight_next;
        state_reg     <= in_flight_next ? ST_WAIT : ST_REQ;
`ifdef MSRV32_MISALIGN_TRAP_EN
        if (bus.iaddr_in[1]) begin
          misaligned_reg <= 1'b1;
          state_reg      <= ST_HOLD;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_msrv32_pc_gen.sv
// Bench for msrv32_pc_gen: directed scenarios plus randomized traffic against a stream-level
// reference (granted and delivered addresses restart at each redirect target and advance by 4).
module tb_msrv32_pc_gen;
  localparam logic [31:0] BOOT = 32'h0000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  msrv32_pc_gen_if bus();

  msrv32_pc_gen #(.BOOT_ADDR(BOOT), .NOP_INSTR(NOP)) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  // memory model: one outstanding request, response pend_delay+1 cycles after grant
  bit          pend_valid = 0;
  int          pend_delay = 0;
  logic [31:0] pend_addr  = '0;
  int          gnt_pct    = 100;
  int          dly_fixed  = 0;
  int          dly_max    = 0;

  // stream reference and history
  logic [31:0] exp_grant   = BOOT;
  logic [31:0] exp_deliver = BOOT;
  bit          hold_flag   = 0;
  int          cyc         = 0;
  logic [31:0] g_addr[$];
  int          g_cyc[$];
  int          rv_cyc[$];
  logic [31:0] acc_pc[$];
  int          acc_cyc[$];

  bit          prev_rst = 0, prev_req = 0, prev_gnt = 0, prev_br = 0, prev_valid = 0, prev_rdy = 0;
  logic [31:0] prev_tgt = '0, prev_addr = '0, prev_pc = '0, prev_instr = '0;

  task automatic observe(input bit rst_v, input bit rdy, input bit br, input logic [31:0] tgt);
    if (!prev_rst) begin
      check_val("rst_req",   32'(bus.imem_req_out),    32'd0);
      check_val("rst_valid", 32'(bus.instr_valid_out), 32'd0);
      check_val("rst_addr",  bus.imem_addr_out,        BOOT);
      check_val("rst_instr", bus.instr_out,            NOP);
      check_val("rst_pc",    bus.pc_out,               BOOT);
`ifdef MSRV32_MISALIGN_TRAP_EN
      check_val("rst_mis",   32'(bus.misaligned_out),  32'd0);
`endif
    end else begin
      if (!bus.instr_valid_out) check_val("nop_out", bus.instr_out, NOP);
      if (bus.instr_valid_out && !rdy) check_val("req_full", 32'(bus.imem_req_out), 32'd0);
      if (prev_req && !prev_gnt && !prev_br) begin
        check_val("req_hold",  32'(bus.imem_req_out), 32'd1);
        check_val("addr_hold", bus.imem_addr_out, prev_addr);
      end
      if (prev_valid && !prev_rdy && !prev_br) begin
        check_val("buf_valid", 32'(bus.instr_valid_out), 32'd1);
        check_val("buf_pc",    bus.pc_out, prev_pc);
        check_val("buf_instr", bus.instr_out, prev_instr);
      end
`ifdef MSRV32_MISALIGN_TRAP_EN
      check_val("mis_pulse", 32'(bus.misaligned_out), 32'(prev_br && prev_tgt[1]));
      if (hold_flag) check_val("hold_req", 32'(bus.imem_req_out), 32'd0);
`endif
    end

    if (!rst_v) begin
      exp_grant   = BOOT;
      exp_deliver = BOOT;
      hold_flag   = 0;
    end else begin
      if (bus.imem_req_out && bus.imem_gnt_in) begin
        check_val("grant_addr", bus.imem_addr_out, exp_grant);
        g_addr.push_back(bus.imem_addr_out);
        g_cyc.push_back(cyc);
        if (!br) exp_grant = exp_grant + 32'd4;
      end
      if (bus.instr_valid_out && rdy && !br) begin
        check_val("acc_pc",    bus.pc_out, exp_deliver);
        check_val("acc_instr", bus.instr_out, mem_word(exp_deliver));
        $display("acc cyc=%0d pc=%h instr=%h", cyc, bus.pc_out, bus.instr_out);
        acc_pc.push_back(bus.pc_out);
        acc_cyc.push_back(cyc);
        exp_deliver = exp_deliver + 32'd4;
      end
      if (br) begin
        exp_grant   = {tgt[31:1], 1'b0};
        exp_deliver = {tgt[31:1], 1'b0};
`ifdef MSRV32_MISALIGN_TRAP_EN
        hold_flag   = tgt[1];
`endif
      end
    end

    if (bus.imem_rvalid_in) begin
      pend_valid = 0;
      rv_cyc.push_back(cyc);
    end else if (pend_valid) begin
      pend_delay--;
    end
    if (bus.imem_req_out && bus.imem_gnt_in) begin
      pend_valid = 1;
      pend_delay = (dly_fixed >= 0) ? dly_fixed : int'($urandom_range(dly_max));
      pend_addr  = bus.imem_addr_out;
    end

    prev_rst = rst_v; prev_req = bus.imem_req_out; prev_gnt = bus.imem_gnt_in;
    prev_br = br; prev_tgt = tgt; prev_addr = bus.imem_addr_out;
    prev_valid = bus.instr_valid_out; prev_rdy = rdy;
    prev_pc = bus.pc_out; prev_instr = bus.instr_out;
  endtask

  task automatic step(input bit rst_v, input bit rdy, input bit br, input logic [31:0] tgt);
    @(negedge clk);
    cyc++;
    rst_n                = rst_v;
    bus.instr_ready_in   = rdy;
    bus.branch_taken_in  = br;
    bus.iaddr_in         = tgt;
    bus.imem_rvalid_in   = pend_valid && (pend_delay == 0);
    bus.imem_rdata_in    = bus.imem_rvalid_in ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #1;
    bus.imem_gnt_in = bus.imem_req_out && !pend_valid && ($urandom_range(99) < gnt_pct);
    #1;
    observe(rst_v, rdy, br, tgt);
  endtask

  initial begin
    int rel, first_v, gsz, n8, vmax, acc0;
    logic [31:0] hold_pc, hold_instr;
    bus.branch_taken_in = 0; bus.iaddr_in = '0; bus.imem_gnt_in = 0;
    bus.imem_rvalid_in = 0; bus.imem_rdata_in = '0; bus.instr_ready_in = 0;

    // reset, release with zero-wait memory; grant for 8 gets a 2-cycle delay
    repeat (3) step(0, 1, 0, '0);
    rel = cyc + 1;
    first_v = -1;
    for (int i = 0; i < 20 && g_addr.size() < 3; i++) begin
      step(1, 1, 0, '0);
      if (first_v < 0 && bus.instr_valid_out) first_v = cyc;
      if (g_addr.size() == 2) dly_fixed = 2;
    end
    check_val("boot_grants", g_addr.size(), 3);
    if (g_addr.size() == 3) begin
      check_val("grant0", g_addr[0], 32'h0);
      check_val("grant1", g_addr[1], 32'h4);
      check_val("grant2", g_addr[2], 32'h8);
    end
    check_val("first_valid_cyc", first_v, rel + 3);
    if (acc_cyc.size() >= 2) check_val("throughput", acc_cyc[1] - acc_cyc[0], 2);
    else check_val("acc_count", acc_cyc.size(), 2);

    // redirect while waiting for 8
    dly_fixed = 0;
    step(1, 1, 1, 32'h0000_0105);
    for (int i = 0; i < 20 && g_addr.size() < 4; i++) step(1, 1, 0, '0);
    check_val("redir_grant_cnt", g_addr.size(), 4);
    if (g_addr.size() == 4 && rv_cyc.size() > 0) begin
      check_val("redir_addr", g_addr[3], 32'h0000_0104);
      check_val("redir_after_stale", g_cyc[3], rv_cyc[rv_cyc.size() - 1] + 1);
    end

    // decode stall with a full buffer
    for (int i = 0; i < 20 && !bus.instr_valid_out; i++) step(1, 0, 0, '0);
    check_val("stall_pc", bus.pc_out, 32'h0000_0104);
    hold_pc = bus.pc_out; hold_instr = bus.instr_out;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, '0);
      check_val("stall_req", 32'(bus.imem_req_out), 32'd0);
      check_val("stall_pc_hold", bus.pc_out, hold_pc);
      check_val("stall_instr_hold", bus.instr_out, hold_instr);
    end
    step(1, 1, 0, '0);
    n8 = 0;
    foreach (acc_pc[k]) if (acc_pc[k] == 32'h8) n8++;
    check_val("no_pc8", n8, 0);

    // wrap from the top of the address space
    step(1, 1, 1, 32'hFFFF_FFF8);
    gsz = g_addr.size();
    for (int i = 0; i < 30 && g_addr.size() < gsz + 3; i++) step(1, 1, 0, '0);
    check_val("wrap_cnt", g_addr.size(), gsz + 3);
    if (g_addr.size() >= gsz + 3) begin
      check_val("wrap_a", g_addr[gsz],     32'hFFFF_FFF8);
      check_val("wrap_b", g_addr[gsz + 1], 32'hFFFF_FFFC);
      check_val("wrap_c", g_addr[gsz + 2], 32'h0000_0000);
    end

`ifdef MSRV32_MISALIGN_TRAP_EN
    // misaligned target parks the fetcher until the next redirect
    step(1, 1, 1, 32'h0000_0202);
    gsz = g_addr.size();
    step(1, 1, 0, '0);
    check_val("mis_on", 32'(bus.misaligned_out), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, '0);
      check_val("mis_off", 32'(bus.misaligned_out), 32'd0);
      check_val("mis_noreq", 32'(bus.imem_req_out), 32'd0);
    end
    check_val("mis_nogrant", g_addr.size(), gsz);
    step(1, 1, 1, 32'h0000_0300);
    for (int i = 0; i < 20 && g_addr.size() == gsz; i++) step(1, 1, 0, '0);
    check_val("mis_resume_cnt", g_addr.size(), gsz + 1);
    if (g_addr.size() > gsz) check_val("mis_resume", g_addr[gsz], 32'h0000_0300);
`endif

    // reset while WAIT; the late response must be ignored
    dly_fixed = 3;
    gsz = g_addr.size();
    for (int i = 0; i < 20 && g_addr.size() == gsz; i++) step(1, 1, 0, '0);
    dly_fixed = 0;
    step(0, 1, 0, '0);
    step(0, 1, 0, '0);
    gsz = g_addr.size();
    vmax = 0;
    for (int i = 0; i < 20 && g_addr.size() == gsz; i++) begin
      step(1, 1, 0, '0);
      if (bus.instr_valid_out) vmax = 1;
    end
    check_val("post_rst_valid", vmax, 0);
    check_val("post_rst_cnt", g_addr.size(), gsz + 1);
    if (g_addr.size() > gsz) check_val("post_rst_addr", g_addr[gsz], BOOT);
    for (int i = 0; i < 6; i++) step(1, 1, 0, '0);

    // randomized traffic
    gnt_pct = 60; dly_fixed = -1; dly_max = 2;
    acc0 = acc_pc.size();
    for (int i = 0; i < 1500; i++) begin
      bit rdy, br;
      logic [31:0] tgt;
      rdy = ($urandom_range(99) < 70);
      br  = ($urandom_range(99) < 4);
      tgt = $urandom;
`ifdef MSRV32_MISALIGN_TRAP_EN
      if ($urandom_range(9) != 0) tgt[1] = 1'b0;
`endif
      step(1, rdy, br, tgt);
    end
    check_val("progress", 32'(acc_pc.size() - acc0 > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
